// File: rtl/pru_cmd_sched_if.sv
// rtl/pru_cmd_sched_if.sv - request bus between the two command sources and the PRU scheduler
interface pru_cmd_sched_if;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [41:0] req_cmd0;
   logic [41:0] req_cmd1;

   modport master (output req_valid, output req_cmd0, output req_cmd1, input req_ready);
   modport slave  (input req_valid, input req_cmd0, input req_cmd1, output req_ready);
endinterface

// File: rtl/pru_cmd_sched.sv
// rtl/pru_cmd_sched.sv - round-robin draw command queue feeding the PRU
// Optional START watchdog enabled by macro PRU_SCHED_TIMEOUT_EN.
module pru_cmd_sched #(
   parameter int FIFO_DEPTH     = 4,
   parameter int TIMEOUT_CYCLES = 1048576
) (
   input  logic           clk,
   input  logic           rst_n,
   pru_cmd_sched_if.slave req,
   output logic           pru_start,
   output logic [1:0]     pru_shape,
   output logic [1:0]     pru_color,
   output logic [9:0]     pru_col,
   output logic [8:0]     pru_row,
   output logic [9:0]     pru_width,
   output logic [8:0]     pru_hr,
   input  logic           pru_busy,
   input  logic           pru_done,
   output logic [4:0]     fifo_level,
   output logic           sched_idle,
   output logic [15:0]    done_cnt,
   output logic           timeout_err,
   input  logic           err_clr
);
   typedef enum logic [1:0] {IDLE, LOAD, START, RELEASE} state_t;

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

   state_t        state_q, state_d;
   logic [41:0]   mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [4:0]    level_q, level_d;
   logic          prio_q;
   logic [41:0]   fields_q;
   logic [15:0]   done_cnt_q, done_cnt_d;

   logic          can_push, push, pop, done_evt, wd_expired;
   logic [1:0]    grant;
   logic [41:0]   push_cmd;
   logic          cfg_unused;

   // Space is judged on the registered level only, so a same-cycle pop never frees a slot.
   always_comb begin
      can_push = (level_q < 5'(FIFO_DEPTH));
      grant    = 2'b00;
      if (can_push) begin
         if (req.req_valid[0] && (!req.req_valid[1] || !prio_q)) begin
            grant[0] = 1'b1;
         end else if (req.req_valid[1]) begin
            grant[1] = 1'b1;
         end
      end
   end

   assign req.req_ready = grant;
   assign push          = |grant;
   assign push_cmd      = grant[1] ? req.req_cmd1 : req.req_cmd0;

   always_comb begin
      state_d  = state_q;
      pop      = 1'b0;
      done_evt = 1'b0;
      case (state_q)
         IDLE: begin
            if (level_q != 5'd0) begin
               pop     = 1'b1;
               state_d = LOAD;
            end
         end
         LOAD: state_d = START;
         START: begin
            if (pru_done) begin
               done_evt = 1'b1;
               state_d  = RELEASE;
            end else if (wd_expired) begin
               state_d  = RELEASE;
            end
         end
         RELEASE: begin
            if (!pru_done) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      level_d = level_q;
      case ({push, pop})
         2'b10:   level_d = level_q + 5'd1;
         2'b01:   level_d = level_q - 5'd1;
         default: level_d = level_q;
      endcase
   end

   assign done_cnt_d = done_cnt_q + 16'(done_evt);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         prio_q     <= 1'b0;
         fields_q   <= '0;
         done_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         level_q    <= level_d;
         done_cnt_q <= done_cnt_d;
         if (push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
            prio_q   <= grant[0];
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
            fields_q <= mem_q[rd_ptr_q];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= push_cmd;
   end

`ifdef PRU_SCHED_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic [TW-1:0] wd_q;
   logic          terr_q;

   // Counter restarts on every entry to START; expiry lands on the TIMEOUT_CYCLES-th START cycle.
   assign wd_expired = (state_q == START) && (wd_q == TW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wd_q   <= '0;
         terr_q <= 1'b0;
      end else begin
         wd_q <= (state_q == START) ? wd_q + 1'b1 : '0;
         if (wd_expired && !pru_done) begin
            terr_q <= 1'b1;
         end else if (err_clr) begin
            terr_q <= 1'b0;
         end
      end
   end

   assign timeout_err = terr_q;
   assign cfg_unused  = pru_busy;
`else
   assign wd_expired  = 1'b0;
   assign timeout_err = 1'b0;
   assign cfg_unused  = pru_busy ^ err_clr ^ (TIMEOUT_CYCLES == 0);
`endif

   assign pru_start  = (state_q == START);
   assign {pru_shape, pru_color, pru_col, pru_row, pru_width, pru_hr} = fields_q;
   assign fifo_level = level_q;
   assign sched_idle = (state_q == IDLE) && (level_q == 5'd0);
   assign done_cnt   = done_cnt_q;
endmodule

// File: tb/tb_pru_cmd_sched.sv
// tb/tb_pru_cmd_sched.sv - vector table, directed corner cases and random run against a queue model
module tb_pru_cmd_sched;
   localparam int DEPTH = 4;
   localparam int TMO   = 16;
`ifdef PRU_SCHED_TIMEOUT_EN
   localparam bit TMO_ON = 1'b1;
`else
   localparam bit TMO_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        pru_start, sched_idle, timeout_err;
   logic [1:0]  pru_shape, pru_color;
   logic [9:0]  pru_col, pru_width;
   logic [8:0]  pru_row, pru_hr;
   logic [4:0]  fifo_level;
   logic [15:0] done_cnt;
   logic        pru_busy = 1'b0;
   logic        pru_done = 1'b0;
   logic        err_clr = 1'b0;
   logic [41:0] fields;

   always #5 clk = ~clk;

   pru_cmd_sched_if bus ();

   pru_cmd_sched #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .rst_n(rst_n), .req(bus),
      .pru_start(pru_start), .pru_shape(pru_shape), .pru_color(pru_color),
      .pru_col(pru_col), .pru_row(pru_row), .pru_width(pru_width), .pru_hr(pru_hr),
      .pru_busy(pru_busy), .pru_done(pru_done), .fifo_level(fifo_level),
      .sched_idle(sched_idle), .done_cnt(done_cnt), .timeout_err(timeout_err),
      .err_clr(err_clr)
   );

   assign fields = {pru_shape, pru_color, pru_col, pru_row, pru_width, pru_hr};

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic do_reset;
      bus.req_valid = 2'b00;
      pru_done      = 1'b0;
      err_clr       = 1'b0;
      rst_n         = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic wait_start(input string name);
      int n = 0;
      while (pru_start !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk(name, 64'(pru_start), 64'(1));
   endtask

   typedef struct {
      logic [1:0]  valid;
      logic        done;
      logic [1:0]  ready;
      logic [4:0]  level;
      logic        start;
      logic [15:0] dcnt;
      logic [41:0] flds;
   } vec_t;

   vec_t tbl [13];

   // Reference model: a plain queue plus the draw phase the spec describes.
   logic [41:0] mq [$];
   int          mprio, mstage, mwd;
   logic [41:0] mfields;
   logic [15:0] mdone;
   logic        merr;

   logic [41:0] cmd;
   logic [15:0] dsave;
   logic        stable;
   int          n;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not reach its end");
      $fatal(1);
   end

   initial begin
      bus.req_valid = 2'b00;
      bus.req_cmd0  = '0;
      bus.req_cmd1  = '0;

      tbl[0]  = '{2'b11, 1'b0, 2'b01, 5'd1, 1'b0, 16'd0, 42'd0};
      tbl[1]  = '{2'b11, 1'b0, 2'b10, 5'd1, 1'b0, 16'd0, 42'd100};
      tbl[2]  = '{2'b11, 1'b0, 2'b01, 5'd2, 1'b1, 16'd0, 42'd100};
      tbl[3]  = '{2'b11, 1'b0, 2'b10, 5'd3, 1'b1, 16'd0, 42'd100};
      tbl[4]  = '{2'b11, 1'b0, 2'b01, 5'd4, 1'b1, 16'd0, 42'd100};
      tbl[5]  = '{2'b11, 1'b0, 2'b00, 5'd4, 1'b1, 16'd0, 42'd100};
      tbl[6]  = '{2'b00, 1'b0, 2'b00, 5'd4, 1'b1, 16'd0, 42'd100};
      tbl[7]  = '{2'b10, 1'b0, 2'b00, 5'd4, 1'b1, 16'd0, 42'd100};
      tbl[8]  = '{2'b00, 1'b1, 2'b00, 5'd4, 1'b0, 16'd1, 42'd100};
      tbl[9]  = '{2'b11, 1'b0, 2'b00, 5'd4, 1'b0, 16'd1, 42'd100};
      tbl[10] = '{2'b11, 1'b0, 2'b00, 5'd3, 1'b0, 16'd1, 42'd201};
      tbl[11] = '{2'b11, 1'b0, 2'b10, 5'd4, 1'b1, 16'd1, 42'd201};
      tbl[12] = '{2'b00, 1'b0, 2'b00, 5'd4, 1'b1, 16'd1, 42'd201};

      do_reset;
      chk("rst_level", 64'(fifo_level), 64'(0));
      chk("rst_start", 64'(pru_start), 64'(0));
      chk("rst_idle", 64'(sched_idle), 64'(1));
      chk("rst_dcnt", 64'(done_cnt), 64'(0));
      chk("rst_fields", 64'(fields), 64'(0));
      chk("rst_terr", 64'(timeout_err), 64'(0));

      // Contention, full FIFO, and full-at-pop sequence
      for (int i = 0; i < 13; i++) begin
         bus.req_valid = tbl[i].valid;
         bus.req_cmd0  = 42'd100 + 42'(i);
         bus.req_cmd1  = 42'd200 + 42'(i);
         pru_done      = tbl[i].done;
         #1;
         chk($sformatf("vec%0d_ready", i), 64'(bus.req_ready), 64'(tbl[i].ready));
         @(negedge clk);
         chk($sformatf("vec%0d_level", i), 64'(fifo_level), 64'(tbl[i].level));
         chk($sformatf("vec%0d_start", i), 64'(pru_start), 64'(tbl[i].start));
         chk($sformatf("vec%0d_dcnt", i), 64'(done_cnt), 64'(tbl[i].dcnt));
         chk($sformatf("vec%0d_fields", i), 64'(fields), 64'(tbl[i].flds));
      end

      // Single command with a 50-cycle draw
      do_reset;
      cmd = {2'b01, 2'b10, 10'd100, 9'd200, 10'd0, 9'd20};
      bus.req_cmd0  = cmd;
      bus.req_valid = 2'b01;
      #1;
      chk("single_ready", 64'(bus.req_ready), 64'(2'b01));
      @(negedge clk);
      bus.req_valid = 2'b00;
      chk("single_start_n0", 64'(pru_start), 64'(0));
      @(negedge clk);
      chk("single_start_n1", 64'(pru_start), 64'(0));
      @(negedge clk);
      chk("single_start_n2", 64'(pru_start), 64'(1));
      chk("single_fields", 64'(fields), 64'(cmd));
      stable = 1'b1;
      repeat (49) begin
         @(negedge clk);
         if (pru_start !== 1'b1 || fields !== cmd) stable = 1'b0;
      end
      chk("single_hold", 64'(stable), 64'(1));
      pru_done = 1'b1;
      @(negedge clk);
      chk("single_release_start", 64'(pru_start), 64'(0));
      chk("single_release_fields", 64'(fields), 64'(cmd));
      chk("single_dcnt", 64'(done_cnt), 64'(1));
      pru_done = 1'b0;
      @(negedge clk);
      chk("single_idle", 64'(sched_idle), 64'(1));

      // Reset during START with three queued
      bus.req_valid = 2'b01;
      for (int i = 0; i < 4; i++) begin
         bus.req_cmd0 = 42'(i + 1);
         @(negedge clk);
      end
      bus.req_valid = 2'b00;
      chk("midrst_pre_level", 64'(fifo_level), 64'(3));
      chk("midrst_pre_start", 64'(pru_start), 64'(1));
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_start", 64'(pru_start), 64'(0));
      chk("midrst_level", 64'(fifo_level), 64'(0));
      chk("midrst_dcnt", 64'(done_cnt), 64'(0));
      chk("midrst_idle", 64'(sched_idle), 64'(1));
      @(negedge clk);
      rst_n = 1'b1;

      // done_cnt wrap
      force dut.done_cnt_q = 16'hFFFF;
      @(negedge clk);
      release dut.done_cnt_q;
      @(negedge clk);
      chk("wrap_pre", 64'(done_cnt), 64'(16'hFFFF));
      bus.req_cmd0  = 42'h155;
      bus.req_valid = 2'b01;
      @(negedge clk);
      bus.req_valid = 2'b00;
      wait_start("wrap_start");
      pru_done = 1'b1;
      @(negedge clk);
      chk("wrap_zero", 64'(done_cnt), 64'(0));
      pru_done = 1'b0;
      @(negedge clk);

      // Watchdog behaviour (or its absence)
      dsave = done_cnt;
      bus.req_valid = 2'b01;
      @(negedge clk);
      bus.req_valid = 2'b00;
      wait_start("tmo_start");
`ifdef PRU_SCHED_TIMEOUT_EN
      n = 0;
      while (pru_start === 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("tmo_cycles", 64'(n), 64'(TMO));
      chk("tmo_err_set", 64'(timeout_err), 64'(1));
      chk("tmo_dcnt", 64'(done_cnt), 64'(dsave));
      @(negedge clk);
      chk("tmo_idle", 64'(sched_idle), 64'(1));
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      chk("tmo_err_clr", 64'(timeout_err), 64'(0));
`else
      repeat (2 * TMO) @(negedge clk);
      chk("notmo_start", 64'(pru_start), 64'(1));
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      chk("notmo_err", 64'(timeout_err), 64'(0));
      pru_done = 1'b1;
      @(negedge clk);
      chk("notmo_dcnt", 64'(done_cnt), 64'(dsave + 16'd1));
      pru_done = 1'b0;
`endif

      // Random traffic against the reference model
      do_reset;
      mq.delete();
      mprio = 0; mstage = 0; mwd = 0; mfields = '0; mdone = '0; merr = 1'b0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         int          g;
         logic [1:0]  v;
         logic [1:0]  exp_ready;
         logic        tmo_hit;

         chk("rnd_level", 64'(fifo_level), 64'(mq.size()));
         chk("rnd_start", 64'(pru_start), 64'(mstage == 2));
         chk("rnd_idle", 64'(sched_idle), 64'(mstage == 0 && mq.size() == 0));
         chk("rnd_dcnt", 64'(done_cnt), 64'(mdone));
         chk("rnd_fields", 64'(fields), 64'(mfields));
         chk("rnd_terr", 64'(timeout_err), 64'(merr));

         if ((cyc % 500) < 250) v = 2'($urandom);
         else v = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
         bus.req_valid = v;
         bus.req_cmd0  = 42'({$urandom, $urandom});
         bus.req_cmd1  = 42'({$urandom, $urandom});
         pru_done      = ($urandom_range(0, 2) == 0);
         pru_busy      = 1'($urandom);
         err_clr       = ($urandom_range(0, 15) == 0);
         #1;

         g = -1;
         if (mq.size() < DEPTH) begin
            if (v == 2'b11) g = mprio;
            else if (v[0]) g = 0;
            else if (v[1]) g = 1;
         end
         exp_ready = (g == 0) ? 2'b01 : (g == 1) ? 2'b10 : 2'b00;
         chk("rnd_ready", 64'(bus.req_ready), 64'(exp_ready));

         tmo_hit = 1'b0;
         case (mstage)
            0: if (mq.size() > 0) begin
               mfields = mq.pop_front();
               mstage  = 1;
            end
            1: begin
               mstage = 2;
               mwd    = 0;
            end
            2: if (pru_done) begin
               mstage = 3;
               mdone  = mdone + 16'd1;
            end else if (TMO_ON && mwd == TMO - 1) begin
               mstage  = 3;
               tmo_hit = 1'b1;
            end else begin
               mwd++;
            end
            default: if (!pru_done) mstage = 0;
         endcase
         if (tmo_hit) merr = 1'b1;
         else if (TMO_ON && err_clr) merr = 1'b0;

         if (g == 0) mq.push_back(bus.req_cmd0);
         if (g == 1) mq.push_back(bus.req_cmd1);
         if (g >= 0) mprio = (g == 0) ? 1 : 0;

         @(negedge clk);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/pru_cmd_sched.md
PRU_CMD_SCHED -- requirements
Module: pru_cmd_sched

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 4, giving the number of queued draw commands (power of two, 2..16).
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 1048576, giving the watchdog limit in clk cycles.
REQ-003 The block SHALL have these ports (name  direction  width  meaning):
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- req_valid  in  2  command offered; bit0 = CPU MMIO, bit1 = sprite engine
- req_ready  out  2  command accepted this cycle
- req_cmd0, req_cmd1  in  42 each  {shape[41:40], color[39:38], col[37:28], row[27:19], width[18:9], height_radius[8:0]}
- pru_start  out  1  draw start to PRU
- pru_shape  out  2  shape select to PRU
- pru_color  out  2  color to PRU
- pru_col  out  10  column to PRU
- pru_row  out  9  row to PRU
- pru_width  out  10  width to PRU
- pru_hr  out  9  height/radius to PRU
- pru_busy, pru_done  in  1 each  PRU status
- fifo_level  out  5  queued entries
- sched_idle  out  1  FIFO empty and FSM in IDLE
- done_cnt  out  16  completed commands
- timeout_err  out  1  sticky watchdog flag
- err_clr  in  1  clears timeout_err

Function
REQ-004 The block SHALL grant at most one requester per cycle, and only when fifo_level < FIFO_DEPTH at the start of the cycle; a same-cycle pop does not free space for a same-cycle push.
REQ-005 Arbitration SHALL be round-robin: after a grant to port i, port 1-i has priority next; the priority pointer resets to port 0.
REQ-006 req_ready[i] SHALL be combinational, high exactly when port i is granted; a granted command SHALL be pushed at that clock edge.
REQ-007 The FIFO SHALL be first-in first-out; its pointers SHALL wrap modulo FIFO_DEPTH; fifo_level SHALL reflect simultaneous push and pop, which leave it unchanged.
REQ-008 The FSM SHALL have states IDLE, LOAD, START and RELEASE.
REQ-009 IDLE -> LOAD when the FIFO is non-empty; the head entry SHALL be popped and registered onto the pru_* field outputs.
REQ-010 LOAD -> START unconditionally; pru_start SHALL be high throughout START.
REQ-011 START -> RELEASE when pru_done = 1; pru_start SHALL be low in RELEASE; done_cnt SHALL increment by 1 on this transition, wrapping at 65535 -> 0.
REQ-012 RELEASE -> IDLE when pru_done = 0.
REQ-013 The pru_* field outputs SHALL hold constant from LOAD through RELEASE.
REQ-014 With the FSM in IDLE and the FIFO empty, a command accepted at edge N SHALL produce pru_start high after edge N+2.
REQ-015 pru_busy SHALL be monitored only; a pru_done already high on entry to START SHALL be honoured on the next edge.
REQ-016 sched_idle SHALL be high only in IDLE with fifo_level = 0.

Reset
REQ-017 On rst_n low, the block SHALL asynchronously reach: FSM in IDLE, FIFO emptied, fifo_level = 0, pru_start = 0, all pru_* fields = 0, done_cnt = 0, timeout_err = 0, priority pointer = port 0, sched_idle = 1.
REQ-018 Reset asserted mid-command SHALL drop pru_start immediately and discard all queued commands.

Configuration
REQ-019 With macro PRU_SCHED_TIMEOUT_EN defined, a counter SHALL run in START; on reaching TIMEOUT_CYCLES it SHALL force START -> RELEASE without incrementing done_cnt and set timeout_err.
REQ-020 With PRU_SCHED_TIMEOUT_EN defined, err_clr SHALL clear timeout_err, and a timeout in the same cycle SHALL take precedence and set it.
REQ-021 Without PRU_SCHED_TIMEOUT_EN, no watchdog counter SHALL exist, timeout_err SHALL be constant 0, and err_clr SHALL be ignored.

Verification
REQ-022 Single command: req_cmd0 = {01,10,100,200,0,20} valid one cycle, PRU model done after 50 cycles -> pru_start high 2 cycles after accept, fields stable, done_cnt = 1, sched_idle = 1 after done falls.
REQ-023 Contention: both ports valid continuously -> grants alternate 0,1,0,1,...; with pru_done held low, req_ready stays low once fifo_level = 4.
REQ-024 Full plus pop: FIFO full at the pop cycle, both ports valid -> no grant that cycle, fifo_level = 3, grant on the next cycle.
REQ-025 Reset mid-draw: rst_n low during START with 3 queued -> pru_start = 0, fifo_level = 0, done_cnt = 0 immediately.
REQ-026 Timeout (macro defined, TIMEOUT_CYCLES = 16): pru_done never rises -> pru_start low after 16 START cycles, timeout_err = 1, done_cnt unchanged; err_clr pulse -> timeout_err = 0.
REQ-027 done_cnt wrap: preload via 65536 completions (or force) -> done_cnt wraps to 0.
